rvh_l1d_amo_rsv_ctrl: RTL and testbench
=======================================

RVH_L1D_AMO_RSV_CTRL -- requirements
Module: rvh_l1d_amo_rsv_ctrl

Interface
REQ-001 SHALL have parameter N_ST_PORT, default 2: number of LSU store request ports (range 1..4).
REQ-002 SHALL have parameter N_WB_PORT, default LSU_DATA_PIPE_COUNT: number of ROB writeback ports matched for AMO completion.
REQ-003 SHALL have parameter RSV_TIMEOUT, default 64: maximum reservation lifetime in idle cycles (range 1..1023).
REQ-004 SHALL have ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active high.
- ls_pipe_amo_ctrl_st_req_{vld,is_fence}_i  in  N_ST_PORT  store request valid / fence flag.
- ls_pipe_amo_ctrl_st_req_{rob_tag,prd,opcode,paddr,data}_i  in  N_ST_PORT x (ROB_TAG_WIDTH, PREG_TAG_WIDTH, STU_OP_WIDTH, PADDR_WIDTH, XLEN)  request payload.
- ls_pipe_amo_ctrl_st_req_rdy_o  out  N_ST_PORT  request accepted.
- amo_ctrl_stb_st_req_{vld,is_fence}_o  out  N_ST_PORT  request valid / fence flag to STB.
- amo_ctrl_stb_st_req_{rob_tag,prd,opcode,paddr,data}_o  out  as inputs  payload to STB.
- amo_ctrl_stb_st_req_rdy_i  in  N_ST_PORT  STB ready.
- amo_ctrl_stb_st_req_no_fence_wb_resp_o  out  1  internal flush; no ROB response.
- amo_ctrl_stb_st_req_sc_rt_check_succ_o  out  1  SC reservation check result.
- l1d_rob_wb_vld_i / l1d_rob_wb_rob_tag_i  in  N_WB_PORT / N_WB_PORT x ROB_TAG_WIDTH  ROB writeback.
- snp_inv_vld_i / snp_inv_line_addr_i  in  1 / L1D_STB_LINE_ADDR_SIZE  snoop invalidation of a line.
- evict_vld_i / evict_line_addr_i  in  1 / L1D_STB_LINE_ADDR_SIZE  L1D eviction of a line.
- in_amo_state_o  out  1  FSM not IDLE.
- rsv_vld_o  out  1  reservation currently valid (debug/perf).

Function
REQ-005 SHALL classify a port request as AMO when its opcode is any STU_LR*, STU_SC* or STU_AMO* encoding.
REQ-006 SHALL treat port k's AMO as oldest when no port j<k is valid; only then SHALL port k be ready while IDLE.
REQ-007 IDLE: ports below the lowest-index AMO port SHALL forward to STB unchanged (vld, rdy pass-through); that AMO port (if not oldest) and all higher ports SHALL be held not-ready with STB valid low.
REQ-008 While in_amo_state_o=1, all rdy_o and all STB valids except port 0 SHALL be 0; port 0 SHALL carry the registered AMO payload.
REQ-009 FSM states IDLE, FLUSH_1, SEND, FLUSH_2, WAIT; each of FLUSH_1/SEND/FLUSH_2 asserts STB port-0 valid (is_fence=1 in FLUSH states, 0 in SEND) and advances on the port-0 STB handshake; SEND and both FLUSH states SHALL hold indefinitely while STB is not ready.
REQ-010 IDLE->FLUSH_1 on AMO accept handshake, capturing payload in the same edge; WAIT->IDLE when any writeback port has valid with rob_tag equal to captured rob_tag.
REQ-011 Minimum AMO occupancy SHALL be 4 cycles from accept to IDLE (all STB ready, writeback in first WAIT cycle).
REQ-012 no_fence_wb_resp_o SHALL equal in_amo_state_o.
REQ-013 Reservation set: in WAIT on completion of an LR, valid<=1, line<=captured paddr line, counter<=RSV_TIMEOUT.
REQ-014 Reservation clear (any of): a valid non-fence store on any port handshaking with the STB whose line matches (the LR itself excluded); snoop or evict line match; SC completion; counter reaching 0.
REQ-015 Set and clear in the same cycle: clear SHALL win (valid=0).
REQ-016 Counter SHALL decrement by 1 per cycle only while valid and FSM is IDLE; frozen otherwise.
REQ-017 sc_rt_check_succ_o SHALL be 1 iff reservation valid and captured paddr equals reserved line (line-address compare, L1D_STB_LINE_ADDR_SIZE MSBs).

Reset
REQ-018 On rst: FSM=IDLE, reservation valid=0, counter=0; hence in_amo_state_o=0, rsv_vld_o=0, sc_rt_check_succ_o=0, all STB valids follow inputs with no AMO present.
REQ-019 Reset mid-AMO SHALL abandon the operation; no further STB request SHALL be issued for it.

Structure
REQ-020 FSM enum and captured-request struct SHALL live in rvh_l1d_pkg; line-address width SHALL reuse L1D_STB_LINE_ADDR_SIZE.
REQ-021 Reservation entry (valid, line, timeout counter, clear logic) SHALL be a sub-module rvh_l1d_amo_rsv_entry.

Verification
REQ-022 AMOADD.D on port 0, STB always ready, writeback 1 cycle later -> STB port 0 sees fence, AMO, fence on 3 consecutive cycles; IDLE after 4 cycles.
REQ-023 Port 0 normal store, port 1 LR.W same cycle -> port 0 forwarded, port 1 rdy=0; LR accepted next cycle.
REQ-024 LR.D 0x1000, SC.D 0x1008 (same line) -> sc_rt_check_succ_o=1 during SC; reservation cleared after SC.
REQ-025 LR.D 0x1000, then port-1 store to 0x1010 -> reservation cleared; following SC sees succ=0.
REQ-026 RSV_TIMEOUT=4, LR then 4 IDLE cycles -> rsv_vld_o=0 on 5th; snoop to line during LR WAIT completion -> valid stays 0.
REQ-027 rst asserted in SEND with STB not ready -> next cycle IDLE, port-0 STB valid low.

Source files
------------

// File: rtl/rvh_l1d_pkg.sv
// Shared L1D types for the AMO/reservation controller: widths, store opcodes,
// AMO FSM state and the captured-request payload.
package rvh_l1d_pkg;

   localparam int unsigned XLEN                   = 64;
   localparam int unsigned PADDR_WIDTH            = 56;
   localparam int unsigned ROB_TAG_WIDTH          = 6;
   localparam int unsigned PREG_TAG_WIDTH         = 7;
   localparam int unsigned STU_OP_WIDTH           = 5;
   localparam int unsigned LSU_DATA_PIPE_COUNT    = 2;
   localparam int unsigned L1D_LINE_OFFSET_WIDTH  = 6;
   localparam int unsigned L1D_STB_LINE_ADDR_SIZE = PADDR_WIDTH - L1D_LINE_OFFSET_WIDTH;

   // LR, SC and AMO encodings are kept contiguous so classification is a range check
   localparam logic [STU_OP_WIDTH-1:0] STU_SB       = 5'd0;
   localparam logic [STU_OP_WIDTH-1:0] STU_SH       = 5'd1;
   localparam logic [STU_OP_WIDTH-1:0] STU_SW       = 5'd2;
   localparam logic [STU_OP_WIDTH-1:0] STU_SD       = 5'd3;
   localparam logic [STU_OP_WIDTH-1:0] STU_LRW      = 5'd4;
   localparam logic [STU_OP_WIDTH-1:0] STU_LRD      = 5'd5;
   localparam logic [STU_OP_WIDTH-1:0] STU_SCW      = 5'd6;
   localparam logic [STU_OP_WIDTH-1:0] STU_SCD      = 5'd7;
   localparam logic [STU_OP_WIDTH-1:0] STU_AMOSWAPW = 5'd8;
   localparam logic [STU_OP_WIDTH-1:0] STU_AMOSWAPD = 5'd9;
   localparam logic [STU_OP_WIDTH-1:0] STU_AMOADDW  = 5'd10;
   localparam logic [STU_OP_WIDTH-1:0] STU_AMOADDD  = 5'd11;
   localparam logic [STU_OP_WIDTH-1:0] STU_AMOANDW  = 5'd12;
   localparam logic [STU_OP_WIDTH-1:0] STU_AMOANDD  = 5'd13;
   localparam logic [STU_OP_WIDTH-1:0] STU_AMOORW   = 5'd14;
   localparam logic [STU_OP_WIDTH-1:0] STU_AMOORD   = 5'd15;
   localparam logic [STU_OP_WIDTH-1:0] STU_AMOXORW  = 5'd16;
   localparam logic [STU_OP_WIDTH-1:0] STU_AMOXORD  = 5'd17;
   localparam logic [STU_OP_WIDTH-1:0] STU_AMOMAXW  = 5'd18;
   localparam logic [STU_OP_WIDTH-1:0] STU_AMOMAXD  = 5'd19;
   localparam logic [STU_OP_WIDTH-1:0] STU_AMOMAXUW = 5'd20;
   localparam logic [STU_OP_WIDTH-1:0] STU_AMOMAXUD = 5'd21;
   localparam logic [STU_OP_WIDTH-1:0] STU_AMOMINW  = 5'd22;
   localparam logic [STU_OP_WIDTH-1:0] STU_AMOMIND  = 5'd23;
   localparam logic [STU_OP_WIDTH-1:0] STU_AMOMINUW = 5'd24;
   localparam logic [STU_OP_WIDTH-1:0] STU_AMOMINUD = 5'd25;

   typedef enum logic [2:0] {
      StIdle,
      StFlush1,
      StSend,
      StFlush2,
      StWait
   } amo_state_e;

   typedef struct packed {
      logic [ROB_TAG_WIDTH-1:0]  rob_tag;
      logic [PREG_TAG_WIDTH-1:0] prd;
      logic [STU_OP_WIDTH-1:0]   opcode;
      logic [PADDR_WIDTH-1:0]    paddr;
      logic [XLEN-1:0]           data;
   } amo_req_t;

   function automatic logic is_amo_op(input logic [STU_OP_WIDTH-1:0] op);
      return (op >= STU_LRW) && (op <= STU_AMOMINUD);
   endfunction

   function automatic logic is_lr_op(input logic [STU_OP_WIDTH-1:0] op);
      return (op == STU_LRW) || (op == STU_LRD);
   endfunction

   function automatic logic is_sc_op(input logic [STU_OP_WIDTH-1:0] op);
      return (op == STU_SCW) || (op == STU_SCD);
   endfunction

   function automatic logic [L1D_STB_LINE_ADDR_SIZE-1:0] line_of(
      input logic [PADDR_WIDTH-1:0] paddr
   );
      return paddr[PADDR_WIDTH-1 -: L1D_STB_LINE_ADDR_SIZE];
   endfunction

endpackage

// File: rtl/rvh_l1d_amo_rsv_entry.sv
// Single LR/SC reservation: valid bit, reserved line and an idle-cycle lifetime counter.
// Any clear source in the same cycle as a set wins.
module rvh_l1d_amo_rsv_entry
   import rvh_l1d_pkg::*;
#(
   parameter int unsigned N_ST_PORT   = 2,
   parameter int unsigned RSV_TIMEOUT = 64
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              tick_i,
   input  logic                              set_i,
   input  logic [L1D_STB_LINE_ADDR_SIZE-1:0] set_line_i,
   input  logic                              clr_i,
   input  logic                              snp_inv_vld_i,
   input  logic [L1D_STB_LINE_ADDR_SIZE-1:0] snp_inv_line_addr_i,
   input  logic                              evict_vld_i,
   input  logic [L1D_STB_LINE_ADDR_SIZE-1:0] evict_line_addr_i,
   input  logic [N_ST_PORT-1:0]              st_clr_vld_i,
   input  logic [L1D_STB_LINE_ADDR_SIZE-1:0] st_clr_line_i [N_ST_PORT-1:0],
   output logic                              rsv_vld_o,
   output logic [L1D_STB_LINE_ADDR_SIZE-1:0] rsv_line_o
);

   localparam int unsigned CntW = 10;

   logic                              valid_q, valid_d;
   logic [L1D_STB_LINE_ADDR_SIZE-1:0] line_q, line_d;
   logic [CntW-1:0]                   cnt_q, cnt_d;
   logic [L1D_STB_LINE_ADDR_SIZE-1:0] tgt_line;
   logic                              st_hit;
   logic                              expire;
   logic                              kill;

   always_comb begin
      // Compare against the incoming line on a set so a same-cycle snoop still kills it
      tgt_line = set_i ? set_line_i : line_q;
      st_hit   = 1'b0;
      for (int k = 0; k < N_ST_PORT; k++) begin
         if (st_clr_vld_i[k] && (st_clr_line_i[k] == tgt_line)) begin
            st_hit = 1'b1;
         end
      end
      expire = valid_q && tick_i && (cnt_q <= CntW'(1));
      kill   = clr_i || st_hit || expire
            || (snp_inv_vld_i && (snp_inv_line_addr_i == tgt_line))
            || (evict_vld_i && (evict_line_addr_i == tgt_line));

      valid_d = valid_q;
      line_d  = line_q;
      cnt_d   = cnt_q;
      if (set_i) begin
         valid_d = 1'b1;
         line_d  = set_line_i;
         cnt_d   = CntW'(RSV_TIMEOUT);
      end else if (valid_q && tick_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - CntW'(1);
      end
      if (kill) begin
         valid_d = 1'b0;
         cnt_d   = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= 1'b0;
         line_q  <= '0;
         cnt_q   <= '0;
      end else begin
         valid_q <= valid_d;
         line_q  <= line_d;
         cnt_q   <= cnt_d;
      end
   end

   assign rsv_vld_o  = valid_q;
   assign rsv_line_o = line_q;

endmodule

// File: rtl/rvh_l1d_amo_rsv_ctrl.sv
// Serialises LR/SC/AMO requests in front of the store buffer (fence, op, fence, wait for
// ROB writeback) and tracks the LR reservation used to qualify SC.
module rvh_l1d_amo_rsv_ctrl
   import rvh_l1d_pkg::*;
#(
   parameter int unsigned N_ST_PORT   = 2,
   parameter int unsigned N_WB_PORT   = LSU_DATA_PIPE_COUNT,
   parameter int unsigned RSV_TIMEOUT = 64
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic [N_ST_PORT-1:0]              ls_pipe_amo_ctrl_st_req_vld_i,
   input  logic [N_ST_PORT-1:0]              ls_pipe_amo_ctrl_st_req_is_fence_i,
   input  logic [ROB_TAG_WIDTH-1:0]          ls_pipe_amo_ctrl_st_req_rob_tag_i [N_ST_PORT-1:0],
   input  logic [PREG_TAG_WIDTH-1:0]         ls_pipe_amo_ctrl_st_req_prd_i     [N_ST_PORT-1:0],
   input  logic [STU_OP_WIDTH-1:0]           ls_pipe_amo_ctrl_st_req_opcode_i  [N_ST_PORT-1:0],
   input  logic [PADDR_WIDTH-1:0]            ls_pipe_amo_ctrl_st_req_paddr_i   [N_ST_PORT-1:0],
   input  logic [XLEN-1:0]                   ls_pipe_amo_ctrl_st_req_data_i    [N_ST_PORT-1:0],
   output logic [N_ST_PORT-1:0]              ls_pipe_amo_ctrl_st_req_rdy_o,
   output logic [N_ST_PORT-1:0]              amo_ctrl_stb_st_req_vld_o,
   output logic [N_ST_PORT-1:0]              amo_ctrl_stb_st_req_is_fence_o,
   output logic [ROB_TAG_WIDTH-1:0]          amo_ctrl_stb_st_req_rob_tag_o [N_ST_PORT-1:0],
   output logic [PREG_TAG_WIDTH-1:0]         amo_ctrl_stb_st_req_prd_o     [N_ST_PORT-1:0],
   output logic [STU_OP_WIDTH-1:0]           amo_ctrl_stb_st_req_opcode_o  [N_ST_PORT-1:0],
   output logic [PADDR_WIDTH-1:0]            amo_ctrl_stb_st_req_paddr_o   [N_ST_PORT-1:0],
   output logic [XLEN-1:0]                   amo_ctrl_stb_st_req_data_o    [N_ST_PORT-1:0],
   input  logic [N_ST_PORT-1:0]              amo_ctrl_stb_st_req_rdy_i,
   output logic                              amo_ctrl_stb_st_req_no_fence_wb_resp_o,
   output logic                              amo_ctrl_stb_st_req_sc_rt_check_succ_o,
   input  logic [N_WB_PORT-1:0]              l1d_rob_wb_vld_i,
   input  logic [ROB_TAG_WIDTH-1:0]          l1d_rob_wb_rob_tag_i [N_WB_PORT-1:0],
   input  logic                              snp_inv_vld_i,
   input  logic [L1D_STB_LINE_ADDR_SIZE-1:0] snp_inv_line_addr_i,
   input  logic                              evict_vld_i,
   input  logic [L1D_STB_LINE_ADDR_SIZE-1:0] evict_line_addr_i,
   output logic                              in_amo_state_o,
   output logic                              rsv_vld_o
);

   amo_state_e                        state_q, state_d;
   amo_req_t                          amo_req_q, amo_req_d;
   logic [N_ST_PORT-1:0]              amo_sel;
   logic                              amo_accept;
   logic                              older_vld;
   logic                              blocked;
   logic                              wb_hit;
   logic                              rsv_set;
   logic                              sc_done;
   logic [N_ST_PORT-1:0]              st_clr_vld;
   logic [L1D_STB_LINE_ADDR_SIZE-1:0] st_clr_line [N_ST_PORT-1:0];
   logic [L1D_STB_LINE_ADDR_SIZE-1:0] rsv_line;

   // Port steering: younger ports stall behind the first AMO, which only goes when oldest
   always_comb begin
      older_vld = 1'b0;
      blocked   = 1'b0;
      amo_sel   = '0;
      for (int k = 0; k < N_ST_PORT; k++) begin
         ls_pipe_amo_ctrl_st_req_rdy_o[k]  = 1'b0;
         amo_ctrl_stb_st_req_vld_o[k]      = 1'b0;
         amo_ctrl_stb_st_req_is_fence_o[k] = ls_pipe_amo_ctrl_st_req_is_fence_i[k];
         amo_ctrl_stb_st_req_rob_tag_o[k]  = ls_pipe_amo_ctrl_st_req_rob_tag_i[k];
         amo_ctrl_stb_st_req_prd_o[k]      = ls_pipe_amo_ctrl_st_req_prd_i[k];
         amo_ctrl_stb_st_req_opcode_o[k]   = ls_pipe_amo_ctrl_st_req_opcode_i[k];
         amo_ctrl_stb_st_req_paddr_o[k]    = ls_pipe_amo_ctrl_st_req_paddr_i[k];
         amo_ctrl_stb_st_req_data_o[k]     = ls_pipe_amo_ctrl_st_req_data_i[k];
         if ((state_q == StIdle) && !blocked) begin
            if (ls_pipe_amo_ctrl_st_req_vld_i[k]
                && is_amo_op(ls_pipe_amo_ctrl_st_req_opcode_i[k])) begin
               blocked                          = 1'b1;
               amo_sel[k]                       = !older_vld;
               ls_pipe_amo_ctrl_st_req_rdy_o[k] = !older_vld;
            end else begin
               amo_ctrl_stb_st_req_vld_o[k]     = ls_pipe_amo_ctrl_st_req_vld_i[k];
               ls_pipe_amo_ctrl_st_req_rdy_o[k] = amo_ctrl_stb_st_req_rdy_i[k];
            end
         end
         older_vld = older_vld | ls_pipe_amo_ctrl_st_req_vld_i[k];
      end
      if (state_q != StIdle) begin
         amo_ctrl_stb_st_req_vld_o[0]      = (state_q != StWait);
         amo_ctrl_stb_st_req_is_fence_o[0] = (state_q != StSend);
         amo_ctrl_stb_st_req_rob_tag_o[0]  = amo_req_q.rob_tag;
         amo_ctrl_stb_st_req_prd_o[0]      = amo_req_q.prd;
         amo_ctrl_stb_st_req_opcode_o[0]   = amo_req_q.opcode;
         amo_ctrl_stb_st_req_paddr_o[0]    = amo_req_q.paddr;
         amo_ctrl_stb_st_req_data_o[0]     = amo_req_q.data;
      end
   end

   always_comb begin
      amo_accept = 1'b0;
      amo_req_d  = amo_req_q;
      for (int k = 0; k < N_ST_PORT; k++) begin
         if (amo_sel[k]) begin
            amo_accept = 1'b1;
            amo_req_d  = '{
               rob_tag: ls_pipe_amo_ctrl_st_req_rob_tag_i[k],
               prd:     ls_pipe_amo_ctrl_st_req_prd_i[k],
               opcode:  ls_pipe_amo_ctrl_st_req_opcode_i[k],
               paddr:   ls_pipe_amo_ctrl_st_req_paddr_i[k],
               data:    ls_pipe_amo_ctrl_st_req_data_i[k]
            };
         end
      end
   end

   always_comb begin
      wb_hit = 1'b0;
      for (int i = 0; i < N_WB_PORT; i++) begin
         if (l1d_rob_wb_vld_i[i] && (l1d_rob_wb_rob_tag_i[i] == amo_req_q.rob_tag)) begin
            wb_hit = 1'b1;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:   if (amo_accept)                   state_d = StFlush1;
         StFlush1: if (amo_ctrl_stb_st_req_rdy_i[0]) state_d = StSend;
         StSend:   if (amo_ctrl_stb_st_req_rdy_i[0]) state_d = StFlush2;
         StFlush2: if (amo_ctrl_stb_st_req_rdy_i[0]) state_d = StWait;
         StWait:   if (wb_hit)                       state_d = StIdle;
         default:                                    state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StIdle;
         amo_req_q <= '0;
      end else begin
         state_q   <= state_d;
         amo_req_q <= amo_req_d;
      end
   end

   // Plain stores hitting the line kill the reservation; LR/SC are handled by the FSM
   always_comb begin
      for (int k = 0; k < N_ST_PORT; k++) begin
         st_clr_vld[k]  = amo_ctrl_stb_st_req_vld_o[k] && amo_ctrl_stb_st_req_rdy_i[k]
                       && !amo_ctrl_stb_st_req_is_fence_o[k]
                       && !is_lr_op(amo_ctrl_stb_st_req_opcode_o[k])
                       && !is_sc_op(amo_ctrl_stb_st_req_opcode_o[k]);
         st_clr_line[k] = line_of(amo_ctrl_stb_st_req_paddr_o[k]);
      end
   end

   assign rsv_set = (state_q == StWait) && wb_hit && is_lr_op(amo_req_q.opcode);
   assign sc_done = (state_q == StWait) && wb_hit && is_sc_op(amo_req_q.opcode);

   rvh_l1d_amo_rsv_entry #(
      .N_ST_PORT   (N_ST_PORT),
      .RSV_TIMEOUT (RSV_TIMEOUT)
   ) u_rsv_entry (
      .clk                 (clk),
      .rst                 (rst),
      .tick_i              (state_q == StIdle),
      .set_i               (rsv_set),
      .set_line_i          (line_of(amo_req_q.paddr)),
      .clr_i               (sc_done),
      .snp_inv_vld_i       (snp_inv_vld_i),
      .snp_inv_line_addr_i (snp_inv_line_addr_i),
      .evict_vld_i         (evict_vld_i),
      .evict_line_addr_i   (evict_line_addr_i),
      .st_clr_vld_i        (st_clr_vld),
      .st_clr_line_i       (st_clr_line),
      .rsv_vld_o           (rsv_vld_o),
      .rsv_line_o          (rsv_line)
   );

   assign in_amo_state_o                         = (state_q != StIdle);
   assign amo_ctrl_stb_st_req_no_fence_wb_resp_o = in_amo_state_o;
   assign amo_ctrl_stb_st_req_sc_rt_check_succ_o =
      rsv_vld_o && (line_of(amo_req_q.paddr) == rsv_line);

endmodule

// File: tb/tb_rvh_l1d_amo_rsv_ctrl.sv
// Directed bench for the AMO/reservation controller, two store ports, RSV_TIMEOUT=4.
module tb_rvh_l1d_amo_rsv_ctrl;
   import rvh_l1d_pkg::*;

   localparam int unsigned NSt = 2;
   localparam int unsigned NWb = 2;

   logic                              clk = 1'b0;
   logic                              rst;
   logic [NSt-1:0]                    req_vld, req_fence, req_rdy;
   logic [ROB_TAG_WIDTH-1:0]          req_tag   [NSt-1:0];
   logic [PREG_TAG_WIDTH-1:0]         req_prd   [NSt-1:0];
   logic [STU_OP_WIDTH-1:0]           req_op    [NSt-1:0];
   logic [PADDR_WIDTH-1:0]            req_paddr [NSt-1:0];
   logic [XLEN-1:0]                   req_data  [NSt-1:0];
   logic [NSt-1:0]                    stb_vld, stb_fence, stb_rdy;
   logic [ROB_TAG_WIDTH-1:0]          stb_tag   [NSt-1:0];
   logic [PREG_TAG_WIDTH-1:0]         stb_prd   [NSt-1:0];
   logic [STU_OP_WIDTH-1:0]           stb_op    [NSt-1:0];
   logic [PADDR_WIDTH-1:0]            stb_paddr [NSt-1:0];
   logic [XLEN-1:0]                   stb_data  [NSt-1:0];
   logic                              no_fence, succ;
   logic [NWb-1:0]                    wb_vld;
   logic [ROB_TAG_WIDTH-1:0]          wb_tag [NWb-1:0];
   logic                              snp_vld, evict_vld;
   logic [L1D_STB_LINE_ADDR_SIZE-1:0] snp_line, evict_line;
   logic                              in_amo, rsv_vld;

   int n_chk = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   rvh_l1d_amo_rsv_ctrl #(
      .N_ST_PORT   (NSt),
      .N_WB_PORT   (NWb),
      .RSV_TIMEOUT (4)
   ) dut (
      .clk                                    (clk),
      .rst                                    (rst),
      .ls_pipe_amo_ctrl_st_req_vld_i          (req_vld),
      .ls_pipe_amo_ctrl_st_req_is_fence_i     (req_fence),
      .ls_pipe_amo_ctrl_st_req_rob_tag_i      (req_tag),
      .ls_pipe_amo_ctrl_st_req_prd_i          (req_prd),
      .ls_pipe_amo_ctrl_st_req_opcode_i       (req_op),
      .ls_pipe_amo_ctrl_st_req_paddr_i        (req_paddr),
      .ls_pipe_amo_ctrl_st_req_data_i         (req_data),
      .ls_pipe_amo_ctrl_st_req_rdy_o          (req_rdy),
      .amo_ctrl_stb_st_req_vld_o              (stb_vld),
      .amo_ctrl_stb_st_req_is_fence_o         (stb_fence),
      .amo_ctrl_stb_st_req_rob_tag_o          (stb_tag),
      .amo_ctrl_stb_st_req_prd_o              (stb_prd),
      .amo_ctrl_stb_st_req_opcode_o           (stb_op),
      .amo_ctrl_stb_st_req_paddr_o            (stb_paddr),
      .amo_ctrl_stb_st_req_data_o             (stb_data),
      .amo_ctrl_stb_st_req_rdy_i              (stb_rdy),
      .amo_ctrl_stb_st_req_no_fence_wb_resp_o (no_fence),
      .amo_ctrl_stb_st_req_sc_rt_check_succ_o (succ),
      .l1d_rob_wb_vld_i                       (wb_vld),
      .l1d_rob_wb_rob_tag_i                   (wb_tag),
      .snp_inv_vld_i                          (snp_vld),
      .snp_inv_line_addr_i                    (snp_line),
      .evict_vld_i                            (evict_vld),
      .evict_line_addr_i                      (evict_line),
      .in_amo_state_o                         (in_amo),
      .rsv_vld_o                              (rsv_vld)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      req_vld    = '0;
      req_fence  = '0;
      stb_rdy    = '1;
      wb_vld     = '0;
      snp_vld    = 1'b0;
      evict_vld  = 1'b0;
      snp_line   = '0;
      evict_line = '0;
      for (int k = 0; k < NSt; k++) begin
         req_tag[k]   = '0;
         req_prd[k]   = '0;
         req_op[k]    = STU_SD;
         req_paddr[k] = '0;
         req_data[k]  = '0;
      end
      for (int i = 0; i < NWb; i++) wb_tag[i] = '0;
   endtask

   task automatic drive(input int p, input logic [STU_OP_WIDTH-1:0] op,
                        input logic [PADDR_WIDTH-1:0] pa, input logic [ROB_TAG_WIDTH-1:0] tag);
      req_vld[p]   = 1'b1;
      req_op[p]    = op;
      req_paddr[p] = pa;
      req_tag[p]   = tag;
      req_prd[p]   = 7'(tag) + 7'd1;
      req_data[p]  = {58'h0, tag};
   endtask

   // Full AMO pass with STB always ready and writeback in the first WAIT cycle
   task automatic run_amo(input logic [STU_OP_WIDTH-1:0] op,
                          input logic [PADDR_WIDTH-1:0] pa, input logic [ROB_TAG_WIDTH-1:0] tag);
      drive(0, op, pa, tag);
      step();
      req_vld = '0;
      step();
      step();
      step();
      wb_vld[1] = 1'b1;
      wb_tag[1] = tag;
      step();
      wb_vld = '0;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst = 1'b1;
      step();
      step();
      n_chk++; if (in_amo !== 1'b0) $display("FAIL rst_in_amo got %b want 0", in_amo); else n_pass++;
      n_chk++; if (rsv_vld !== 1'b0) $display("FAIL rst_rsv_vld got %b want 0", rsv_vld); else n_pass++;
      n_chk++; if (succ !== 1'b0) $display("FAIL rst_succ got %b want 0", succ); else n_pass++;
      n_chk++; if (no_fence !== 1'b0) $display("FAIL rst_no_fence got %b want 0", no_fence); else n_pass++;
      rst = 1'b0;
      drive(0, STU_SW, 56'h8000, 6'd3);
      #1;
      n_chk++; if (stb_vld !== 2'b01) $display("FAIL rst_pass_vld got %b want 01", stb_vld); else n_pass++;
      n_chk++; if (req_rdy !== 2'b11) $display("FAIL rst_pass_rdy got %b want 11", req_rdy); else n_pass++;
      step();
      req_vld = '0;
   endtask

   task automatic test_amo_sequence();
      drive(0, STU_AMOADDD, 56'h2000, 6'd5);
      drive(1, STU_SD, 56'h9000, 6'd6);
      #1;
      n_chk++; if (req_rdy !== 2'b01) $display("FAIL amo_acc_rdy got %b want 01", req_rdy); else n_pass++;
      n_chk++; if (stb_vld !== 2'b00) $display("FAIL amo_acc_stbvld got %b want 00", stb_vld); else n_pass++;
      step();
      req_vld = '0;
      n_chk++; if ({in_amo, no_fence, stb_vld, stb_fence[0]} !== 5'b11011)
         $display("FAIL amo_flush1 got %b want 11011", {in_amo, no_fence, stb_vld, stb_fence[0]});
      else n_pass++;
      n_chk++; if (req_rdy !== 2'b00) $display("FAIL amo_busy_rdy got %b want 00", req_rdy); else n_pass++;
      step();
      n_chk++; if ({stb_vld[0], stb_fence[0], stb_op[0]} !== {1'b1, 1'b0, STU_AMOADDD})
         $display("FAIL amo_send_op got %b/%b/%0d want 1/0/%0d", stb_vld[0], stb_fence[0],
                  stb_op[0], STU_AMOADDD);
      else n_pass++;
      n_chk++; if ({stb_paddr[0], stb_tag[0], stb_prd[0]} !== {56'h2000, 6'd5, 7'd6})
         $display("FAIL amo_send_payload got %h/%0d/%0d want 2000/5/6", stb_paddr[0], stb_tag[0],
                  stb_prd[0]);
      else n_pass++;
      step();
      n_chk++; if ({stb_vld[0], stb_fence[0]} !== 2'b11)
         $display("FAIL amo_flush2 got %b want 11", {stb_vld[0], stb_fence[0]}); else n_pass++;
      step();
      n_chk++; if ({in_amo, stb_vld[0]} !== 2'b10)
         $display("FAIL amo_wait got %b want 10", {in_amo, stb_vld[0]}); else n_pass++;
      wb_vld[0] = 1'b1;
      wb_tag[0] = 6'd4;
      step();
      n_chk++; if (in_amo !== 1'b1) $display("FAIL amo_wrong_tag got %b want 1", in_amo); else n_pass++;
      wb_tag[0] = 6'd5;
      step();
      wb_vld = '0;
      n_chk++; if (in_amo !== 1'b0) $display("FAIL amo_done got %b want 0", in_amo); else n_pass++;
   endtask

   task automatic test_lr_sc();
      drive(0, STU_SD, 56'h3000, 6'd8);
      drive(1, STU_LRD, 56'h1000, 6'd7);
      #1;
      n_chk++; if ({req_rdy, stb_vld} !== 4'b0101)
         $display("FAIL order_first got %b want 0101", {req_rdy, stb_vld}); else n_pass++;
      step();
      req_vld[0] = 1'b0;
      #1;
      n_chk++; if (req_rdy[1] !== 1'b1) $display("FAIL order_lr_rdy got %b want 1", req_rdy[1]); else n_pass++;
      step();
      req_vld = '0;
      step();
      step();
      step();
      wb_vld[0] = 1'b1;
      wb_tag[0] = 6'd7;
      step();
      wb_vld = '0;
      n_chk++; if (rsv_vld !== 1'b1) $display("FAIL lr_set got %b want 1", rsv_vld); else n_pass++;
      drive(0, STU_SCD, 56'h1008, 6'd9);
      step();
      req_vld = '0;
      n_chk++; if (succ !== 1'b1) $display("FAIL sc_succ_flush got %b want 1", succ); else n_pass++;
      step();
      n_chk++; if (succ !== 1'b1) $display("FAIL sc_succ_send got %b want 1", succ); else n_pass++;
      step();
      step();
      wb_vld[0] = 1'b1;
      wb_tag[0] = 6'd9;
      step();
      wb_vld = '0;
      n_chk++; if ({rsv_vld, succ} !== 2'b00)
         $display("FAIL sc_clear got %b want 00", {rsv_vld, succ}); else n_pass++;
   endtask

   task automatic test_store_clear();
      run_amo(STU_LRD, 56'h1000, 6'd10);
      drive(1, STU_SD, 56'h1010, 6'd12);
      #1;
      n_chk++; if ({rsv_vld, stb_vld[1]} !== 2'b11)
         $display("FAIL st_pre got %b want 11", {rsv_vld, stb_vld[1]}); else n_pass++;
      step();
      req_vld = '0;
      n_chk++; if (rsv_vld !== 1'b0) $display("FAIL st_clear got %b want 0", rsv_vld); else n_pass++;
      drive(0, STU_SCD, 56'h1000, 6'd11);
      step();
      req_vld = '0;
      n_chk++; if (succ !== 1'b0) $display("FAIL st_sc_fail got %b want 0", succ); else n_pass++;
      step();
      step();
      step();
      wb_vld[0] = 1'b1;
      wb_tag[0] = 6'd11;
      step();
      wb_vld = '0;
   endtask

   task automatic test_timeout_snoop();
      run_amo(STU_LRW, 56'h4000, 6'd12);
      for (int c = 1; c <= 4; c++) begin
         n_chk++; if (rsv_vld !== 1'b1) $display("FAIL tmo_alive_%0d got %b want 1", c, rsv_vld);
         else n_pass++;
         step();
      end
      n_chk++; if (rsv_vld !== 1'b0) $display("FAIL tmo_expire got %b want 0", rsv_vld); else n_pass++;
      drive(0, STU_LRD, 56'h5000, 6'd13);
      step();
      req_vld = '0;
      step();
      step();
      step();
      wb_vld[0] = 1'b1;
      wb_tag[0] = 6'd13;
      snp_vld   = 1'b1;
      snp_line  = 50'h140;
      step();
      wb_vld  = '0;
      snp_vld = 1'b0;
      n_chk++; if (rsv_vld !== 1'b0) $display("FAIL snp_set_clr got %b want 0", rsv_vld); else n_pass++;
      run_amo(STU_LRD, 56'h6000, 6'd14);
      evict_vld  = 1'b1;
      evict_line = 50'h1c0;
      step();
      n_chk++; if (rsv_vld !== 1'b1) $display("FAIL evict_miss got %b want 1", rsv_vld); else n_pass++;
      evict_line = 50'h180;
      step();
      evict_vld = 1'b0;
      n_chk++; if (rsv_vld !== 1'b0) $display("FAIL evict_hit got %b want 0", rsv_vld); else n_pass++;
   endtask

   task automatic test_rst_mid();
      drive(0, STU_AMOSWAPD, 56'h7000, 6'd20);
      step();
      req_vld = '0;
      step();
      stb_rdy[0] = 1'b0;
      step();
      n_chk++; if ({in_amo, stb_vld[0], stb_fence[0]} !== 3'b110)
         $display("FAIL send_hold got %b want 110", {in_amo, stb_vld[0], stb_fence[0]});
      else n_pass++;
      rst = 1'b1;
      step();
      rst = 1'b0;
      n_chk++; if ({in_amo, stb_vld[0]} !== 2'b00)
         $display("FAIL rst_mid got %b want 00", {in_amo, stb_vld[0]}); else n_pass++;
      stb_rdy[0] = 1'b1;
      step();
      n_chk++; if ({in_amo, stb_vld[0]} !== 2'b00)
         $display("FAIL rst_mid_after got %b want 00", {in_amo, stb_vld[0]}); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_amo_sequence();
      test_lr_sc();
      test_store_clear();
      test_timeout_snoop();
      test_rst_mid();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
